// File: rtl/nes_pad_reader_if.sv
// Pad-side and consumer-side signals of the NES controller reader.
// master: the reader (drives the pad strobes and button outputs); slave: its environment.
interface nes_pad_reader_if;
    logic       poll_now;
    logic [1:0] pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [7:0] btns0;
    logic [7:0] btns1;
    logic       valid;
    logic       busy;

    modport master (
        input  poll_now,
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output btns0,
        output btns1,
        output valid,
        output busy
    );

    modport slave (
        output poll_now,
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  btns0,
        input  btns1,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/nes_pad_reader.sv
// NES serial controller reader: strobes up to two pads and shifts in their 8-bit reports.
// Optional macro NES_PAD_DEBOUNCE_EN: outputs update only when two consecutive reads agree.
module nes_pad_reader #(
    parameter int HALF_CYCLES = 6,
    parameter int POLL_CYCLES = 29830
) (
    input  logic              clk,
    input  logic              rst,
    nes_pad_reader_if.master  bus
);
    localparam int PW = $clog2(2 * HALF_CYCLES);
    localparam int CW = $clog2(POLL_CYCLES);
    localparam logic [PW-1:0] LATCH_LAST  = PW'(2 * HALF_CYCLES - 1);
    localparam logic [PW-1:0] HALF_LAST   = PW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] POLL_RELOAD = CW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, PULSE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   phase_reg, phase_next;
    logic [2:0]      index_reg, index_next;
    logic [CW-1:0]   poll_reg, poll_next;
    logic [1:0][7:0] shadow_reg, shadow_next;
    logic [1:0][7:0] btns_reg;
    logic [1:0]      sync1_reg, sync2_reg;
    logic            pad_latch_reg, pad_clk_reg, busy_reg, valid_reg;

    // Plain two-flop synchronizer; no reset so it never masks a live pad line.
    always_ff @(posedge clk) begin
        sync1_reg <= bus.pad_data;
        sync2_reg <= sync1_reg;
    end

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        index_next  = index_reg;
        shadow_next = shadow_reg;
        // The poll counter runs in every state so latch edges stay exactly POLL_CYCLES apart.
        poll_next   = (poll_reg != '0) ? poll_reg - 1'b1 : poll_reg;
        case (state_reg)
            IDLE: begin
                if (poll_reg == '0 || bus.poll_now) begin
                    state_next = LATCH;
                    phase_next = '0;
                    poll_next  = POLL_RELOAD;
                end
            end
            LATCH: begin
                if (phase_reg == LATCH_LAST) begin
                    state_next = SAMPLE;
                    phase_next = '0;
                    index_next = '0;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            SAMPLE: begin
                if (phase_reg == HALF_LAST) begin
                    phase_next = '0;
                    for (int p = 0; p < 2; p++) begin
                        shadow_next[p][index_reg] = ~sync2_reg[p];
                    end
                    state_next = (index_reg == 3'd7) ? DONE : PULSE;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            PULSE: begin
                if (phase_reg == HALF_LAST) begin
                    phase_next = '0;
                    index_next = index_reg + 3'd1;
                    state_next = SAMPLE;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pad strobes and busy are registered from the next state so the pins never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            index_reg     <= '0;
            poll_reg      <= '0;
            shadow_reg    <= '0;
            pad_latch_reg <= 1'b0;
            pad_clk_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            index_reg     <= index_next;
            poll_reg      <= poll_next;
            shadow_reg    <= shadow_next;
            pad_latch_reg <= (state_next == LATCH);
            pad_clk_reg   <= (state_next == PULSE);
            busy_reg      <= (state_next != IDLE);
        end
    end

`ifdef NES_PAD_DEBOUNCE_EN
    logic [1:0][7:0] prev_reg;
    logic [1:0]      take;
    logic [1:0]      changed;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_debounce
        assign take[gi]    = (shadow_reg[gi] == prev_reg[gi]);
        assign changed[gi] = take[gi] && (shadow_reg[gi] != btns_reg[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btns_reg  <= '0;
            prev_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (state_reg == DONE) begin
                for (int p = 0; p < 2; p++) begin
                    if (take[p]) begin
                        btns_reg[p] <= shadow_reg[p];
                    end
                end
                prev_reg  <= shadow_reg;
                valid_reg <= |changed;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            btns_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (state_reg == DONE) begin
                btns_reg  <= shadow_reg;
                valid_reg <= 1'b1;
            end
        end
    end
`endif

    assign bus.pad_latch = pad_latch_reg;
    assign bus.pad_clk   = pad_clk_reg;
    assign bus.busy      = busy_reg;
    assign bus.valid     = valid_reg;
    assign bus.btns0     = btns_reg[0];
    assign bus.btns1     = btns_reg[1];
endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural 4021-style pads plus a transaction-level expectation model.
module tb_nes_pad_reader;
    localparam int H   = 6;
    localparam int P   = 200;
    localparam int TXN = 17 * H + 1;
    localparam int WIN = 110;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nes_pad_reader_if bus ();

    nes_pad_reader #(.HALF_CYCLES(H), .POLL_CYCLES(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    // Pad model: parallel load on latch, shift on each pad_clk rise, active-low output.
    logic [7:0] btn  [2] = '{8'h00, 8'h00};
    logic [7:0] snap [2] = '{8'h00, 8'h00};
    logic [1:0] conn = 2'b11;
    int idx = 0;

    always @(posedge bus.pad_latch) begin
        snap[0] = btn[0];
        snap[1] = btn[1];
    end

    always @(posedge bus.pad_clk or posedge bus.pad_latch) begin
        if (bus.pad_latch) idx = 0;
        else idx = idx + 1;
    end

    always_comb begin
        bus.pad_data = 2'b11;
        for (int p = 0; p < 2; p++) begin
            if (conn[p] && idx < 8) bus.pad_data[p] = ~snap[p][idx[2:0]];
        end
    end

    // Expectation model: what the consumer should see after each completed read.
    logic [7:0] m_out  [2];
    logic [7:0] m_prev [2];

    task automatic model_reset();
        m_out[0] = 8'h00; m_out[1] = 8'h00;
        m_prev[0] = 8'h00; m_prev[1] = 8'h00;
    endtask

    task automatic model_txn(output logic [7:0] x0, output logic [7:0] x1, output int xv);
        logic [7:0] s [2];
        logic [7:0] old [2];
        for (int p = 0; p < 2; p++) begin
            s[p] = conn[p] ? btn[p] : 8'h00;
            old[p] = m_out[p];
        end
`ifdef NES_PAD_DEBOUNCE_EN
        for (int p = 0; p < 2; p++) begin
            if (s[p] == m_prev[p]) m_out[p] = s[p];
            m_prev[p] = s[p];
        end
        xv = (m_out[0] != old[0] || m_out[1] != old[1]) ? 1 : 0;
`else
        m_out[0] = s[0];
        m_out[1] = s[1];
        xv = 1;
`endif
        x0 = m_out[0];
        x1 = m_out[1];
    endtask

    // Observations of one transaction, starting at the negedge where pad_latch has just risen.
    int c_latch, c_busy, c_nclk, c_first, c_bad_space, c_bad_width, c_valid, c_valid_off;
    logic [7:0] c_v0, c_v1, c_end0, c_end1;

    task automatic capture();
        int last_rise = -1;
        int width = 0;
        logic prev_clk = 1'b0;
        c_latch = 0; c_busy = 0; c_nclk = 0; c_first = -1; c_bad_space = 0;
        c_bad_width = 0; c_valid = 0; c_valid_off = -1; c_v0 = 8'hxx; c_v1 = 8'hxx;
        for (int off = 0; off <= WIN; off++) begin
            if (off > 0) @(negedge clk);
            if (bus.pad_latch) c_latch++;
            if (bus.busy) c_busy++;
            if (bus.pad_clk && !prev_clk) begin
                c_nclk++;
                if (c_first < 0) c_first = off;
                else if (off - last_rise != 2 * H) c_bad_space++;
                last_rise = off;
                width = 0;
            end
            if (bus.pad_clk) width++;
            if (!bus.pad_clk && prev_clk && width != H) c_bad_width++;
            prev_clk = bus.pad_clk;
            if (bus.valid) begin
                c_valid++;
                c_valid_off = off;
                c_v0 = bus.btns0;
                c_v1 = bus.btns1;
            end
        end
        c_end0 = bus.btns0;
        c_end1 = bus.btns1;
        txn_no++;
        $display("txn %0d: pads=%02h/%02h conn=%b btns0=%02h btns1=%02h valid_pulses=%0d busy=%0d",
                 txn_no, btn[0], btn[1], conn, c_end0, c_end1, c_valid, c_busy);
    endtask

    task automatic wait_latch(output int n);
        logic last = bus.pad_latch;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (bus.pad_latch && !last) begin
                n = i;
                return;
            end
            last = bus.pad_latch;
        end
        checks++; errors++;
        $display("FAIL latch_timeout: got no latch rise within 400 cycles, required one");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.poll_now = 1'b0;
        btn[0] = 8'h09; btn[1] = 8'h00; conn = 2'b11;
        repeat (3) @(negedge clk);
        checks++; if (bus.pad_latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b expected 0", bus.pad_latch); end
        checks++; if (bus.pad_clk !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b expected 0", bus.pad_clk); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.valid); end
        checks++; if (bus.btns0 !== 8'h00) begin errors++; $display("FAIL rst_btns0: got %02h expected 00", bus.btns0); end
        checks++; if (bus.btns1 !== 8'h00) begin errors++; $display("FAIL rst_btns1: got %02h expected 00", bus.btns1); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (bus.pad_latch !== 1'b1) begin errors++; $display("FAIL first_latch: got %b expected 1", bus.pad_latch); end
    endtask

    task automatic test_basic();
        logic [7:0] x0, x1;
        int xv;
        capture();
        model_txn(x0, x1, xv);
        checks++; if (c_valid !== xv) begin errors++; $display("FAIL basic_valid_cnt: got %0d expected %0d", c_valid, xv); end
        if (xv == 1) begin
            checks++; if (c_valid_off !== TXN) begin errors++; $display("FAIL basic_valid_off: got %0d expected %0d", c_valid_off, TXN); end
            checks++; if (c_v0 !== x0) begin errors++; $display("FAIL basic_btns0: got %02h expected %02h", c_v0, x0); end
        end
        checks++; if (c_end0 !== x0) begin errors++; $display("FAIL basic_hold0: got %02h expected %02h", c_end0, x0); end
        checks++; if (c_end1 !== x1) begin errors++; $display("FAIL basic_hold1: got %02h expected %02h", c_end1, x1); end
    endtask

    task automatic test_waveform();
        logic [7:0] x0, x1;
        int xv, n;
        btn[0] = 8'($urandom); btn[1] = 8'($urandom); conn = 2'b11;
        wait_latch(n);
        capture();
        model_txn(x0, x1, xv);
        checks++; if (c_latch !== 2 * H) begin errors++; $display("FAIL latch_width: got %0d expected %0d", c_latch, 2 * H); end
        checks++; if (c_nclk !== 7) begin errors++; $display("FAIL clk_pulses: got %0d expected 7", c_nclk); end
        checks++; if (c_first !== 3 * H) begin errors++; $display("FAIL first_clk: got %0d expected %0d", c_first, 3 * H); end
        checks++; if (c_bad_space !== 0) begin errors++; $display("FAIL clk_spacing: got %0d bad gaps expected 0", c_bad_space); end
        checks++; if (c_bad_width !== 0) begin errors++; $display("FAIL clk_width: got %0d bad widths expected 0", c_bad_width); end
        checks++; if (c_busy !== TXN) begin errors++; $display("FAIL busy_len: got %0d expected %0d", c_busy, TXN); end
        checks++; if (c_end0 !== x0) begin errors++; $display("FAIL wave_btns0: got %02h expected %02h", c_end0, x0); end
        wait_latch(n);
        checks++; if (WIN + n !== P) begin errors++; $display("FAIL latch_period: got %0d expected %0d", WIN + n, P); end
        capture();
        model_txn(x0, x1, xv);
        checks++; if (c_end1 !== x1) begin errors++; $display("FAIL wave2_btns1: got %02h expected %02h", c_end1, x1); end
    endtask

    task automatic test_two_pads();
        logic [7:0] x0, x1;
        int xv, n;
        btn[0] = 8'h80; btn[1] = 8'h12; conn = 2'b11;
        for (int k = 0; k < 2; k++) begin
            wait_latch(n);
            capture();
            model_txn(x0, x1, xv);
            checks++; if (c_valid !== xv) begin errors++; $display("FAIL two_valid_cnt: got %0d expected %0d", c_valid, xv); end
            checks++; if (c_end0 !== x0) begin errors++; $display("FAIL two_btns0: got %02h expected %02h", c_end0, x0); end
            checks++; if (c_end1 !== x1) begin errors++; $display("FAIL two_btns1: got %02h expected %02h", c_end1, x1); end
        end
    endtask

    task automatic test_poll_now();
        logic [7:0] x0, x1;
        int xv, n;
        int rise_off = -1;
        int vcount = 0;
        logic last;
        btn[0] = 8'h41; btn[1] = 8'h24; conn = 2'b11;
        wait_latch(n);
        last = 1'b1;
        for (int off = 1; off <= 200 && rise_off < 0; off++) begin
            @(negedge clk);
            if (bus.valid) vcount++;
            if (bus.pad_latch && !last) rise_off = off;
            last = bus.pad_latch;
            bus.poll_now = ((off == 50 || off == 150) && rise_off < 0) ? 1'b1 : 1'b0;
        end
        bus.poll_now = 1'b0;
        model_txn(x0, x1, xv);
        checks++; if (rise_off !== 151) begin errors++; $display("FAIL poll_now_rise: got offset %0d expected 151", rise_off); end
        checks++; if (vcount !== xv) begin errors++; $display("FAIL poll_valid_cnt: got %0d expected %0d", vcount, xv); end
        capture();
        model_txn(x0, x1, xv);
        checks++; if (c_busy !== TXN) begin errors++; $display("FAIL poll_busy: got %0d expected %0d", c_busy, TXN); end
        checks++; if (c_end0 !== x0) begin errors++; $display("FAIL poll_btns0: got %02h expected %02h", c_end0, x0); end
        wait_latch(n);
        checks++; if (WIN + n !== P) begin errors++; $display("FAIL poll_period: got %0d expected %0d", WIN + n, P); end
        capture();
        model_txn(x0, x1, xv);
        checks++; if (c_end1 !== x1) begin errors++; $display("FAIL poll2_btns1: got %02h expected %02h", c_end1, x1); end
    endtask

    task automatic test_debounce();
        logic [7:0] x0, x1;
        int xv, n;
        btn[1] = 8'h00; conn = 2'b11;
        for (int k = 0; k < 3; k++) begin
            btn[0] = (k == 1) ? 8'h01 : 8'h00;
            wait_latch(n);
            capture();
            model_txn(x0, x1, xv);
            checks++; if (c_valid !== xv) begin errors++; $display("FAIL deb_valid_cnt%0d: got %0d expected %0d", k, c_valid, xv); end
            checks++; if (c_end0 !== x0) begin errors++; $display("FAIL deb_btns0_%0d: got %02h expected %02h", k, c_end0, x0); end
        end
    endtask

    task automatic test_random();
        logic [7:0] x0, x1;
        int xv, n;
        for (int k = 0; k < 8; k++) begin
            btn[0] = 8'($urandom); btn[1] = 8'($urandom);
            conn = (k < 2) ? 2'($urandom_range(0, 3)) : 2'b11;
            if (k % 3 == 2) begin btn[0] = btn[0]; end
            wait_latch(n);
            capture();
            model_txn(x0, x1, xv);
            checks++; if (c_valid !== xv) begin errors++; $display("FAIL rnd_valid_cnt%0d: got %0d expected %0d", k, c_valid, xv); end
            checks++; if (c_end0 !== x0) begin errors++; $display("FAIL rnd_btns0_%0d: got %02h expected %02h", k, c_end0, x0); end
            checks++; if (c_end1 !== x1) begin errors++; $display("FAIL rnd_btns1_%0d: got %02h expected %02h", k, c_end1, x1); end
            // Re-read the same buttons so the agreeing-read path is exercised too.
            wait_latch(n);
            capture();
            model_txn(x0, x1, xv);
            checks++; if (c_end0 !== x0 || c_end1 !== x1) begin errors++; $display("FAIL rnd_repeat%0d: got %02h/%02h expected %02h/%02h", k, c_end0, c_end1, x0, x1); end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] x0, x1;
        int xv, n;
        btn[0] = 8'h09; btn[1] = 8'h00; conn = 2'b11;
        for (int k = 0; k < 2; k++) begin
            wait_latch(n);
            capture();
            model_txn(x0, x1, xv);
        end
        checks++; if (c_end0 !== 8'h09) begin errors++; $display("FAIL pre_rst_btns0: got %02h expected 09", c_end0); end
        btn[0] = 8'hF0;
        wait_latch(n);
        repeat (62) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.btns0 !== 8'h00) begin errors++; $display("FAIL midrst_btns0: got %02h expected 00", bus.btns0); end
        checks++; if (bus.pad_latch !== 1'b0 || bus.pad_clk !== 1'b0) begin errors++; $display("FAIL midrst_lines: got latch=%b clk=%b expected 0/0", bus.pad_latch, bus.pad_clk); end
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_busy: got busy=%b valid=%b expected 0/0", bus.busy, bus.valid); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (bus.pad_latch !== 1'b1) begin errors++; $display("FAIL post_rst_latch: got %b expected 1", bus.pad_latch); end
        capture();
        model_txn(x0, x1, xv);
        checks++; if (c_busy !== TXN) begin errors++; $display("FAIL post_rst_busy: got %0d expected %0d", c_busy, TXN); end
        checks++; if (c_valid !== xv) begin errors++; $display("FAIL post_rst_valid: got %0d expected %0d", c_valid, xv); end
        checks++; if (c_end0 !== x0) begin errors++; $display("FAIL post_rst_btns0: got %02h expected %02h", c_end0, x0); end
    endtask

    initial begin
        bus.poll_now = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_waveform();
        test_two_pads();
        test_poll_now();
        test_debounce();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
